// File: rtl/phy_lane_arb.sv
// phy_lane_arb: two byte FIFOs arbitrated onto one PHY lane, with COM training.
// Define PHY_LANE_ARB_STRICT_PRIO_EN for fixed priority to requester 0.
module phy_lane_arb #(
    parameter int         DEPTH      = 4,
    parameter logic [7:0] COM_SYMBOL = 8'hBC,
    parameter int         INIT_COMS  = 4
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic [7:0] data_in_0,
    input  logic       valid_in_0,
    output logic       ready_out_0,
    input  logic [7:0] data_in_1,
    input  logic       valid_in_1,
    output logic       ready_out_1,
    input  logic       lane_ready,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       sel_out,
    output logic       link_up
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = (INIT_COMS > 1) ? $clog2(INIT_COMS) : 1;

    typedef enum logic {
        INIT,
        ACTIVE
    } state_t;

    state_t          state;
    logic [NW-1:0]   com_cnt;
    logic            last_grant;
    logic            grant;
    logic            do_pop;

    logic [1:0][7:0] din;
    logic [1:0][7:0] head;
    logic [1:0]      vin;
    logic [1:0]      rdy;
    logic [1:0]      ne;
    logic [1:0]      push;
    logic [1:0]      pop;

    assign din[0] = data_in_0;
    assign din[1] = data_in_1;
    assign vin    = {valid_in_1, valid_in_0};

    assign ready_out_0 = rdy[0];
    assign ready_out_1 = rdy[1];

    // A pop happens only when the lane takes a byte in ACTIVE
    assign do_pop = (state == ACTIVE) && lane_ready && (|ne);

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [7:0]    mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [CW-1:0] occ;

        // Ready is taken from pre-pop occupancy, so a full FIFO never
        // pushes in the same cycle it pops.
        assign rdy[g]  = (occ != CW'(DEPTH));
        assign ne[g]   = (occ != '0);
        assign push[g] = vin[g] & rdy[g];
        assign pop[g]  = do_pop & (grant == 1'(g));
        assign head[g] = mem[rd_ptr];

        // Storage write; contents need no reset
        always_ff @(posedge clk_f) begin
            if (push[g]) begin
                mem[wr_ptr] <= din[g];
            end
        end

        // Pointers wrap naturally at power-of-two depth
        always_ff @(posedge clk_f or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                unique case ({push[g], pop[g]})
                    2'b10:   occ <= occ + CW'(1);
                    2'b01:   occ <= occ - CW'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

    // Grant selection among non-empty requesters
    always_comb begin
        grant = 1'b0;
`ifdef PHY_LANE_ARB_STRICT_PRIO_EN
        grant = !ne[0];
`else
        if (ne[0] && ne[1]) begin
            grant = !last_grant;
        end else begin
            grant = !ne[0];
        end
`endif
    end

    // Training / active FSM with registered lane outputs
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            com_cnt    <= '0;
            data_out   <= COM_SYMBOL;
            valid_out  <= 1'b0;
            sel_out    <= 1'b0;
            link_up    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            unique case (state)
                INIT: begin
                    data_out  <= COM_SYMBOL;
                    valid_out <= 1'b0;
                    link_up   <= 1'b0;
                    if (lane_ready) begin
                        if (com_cnt == NW'(INIT_COMS - 1)) begin
                            state   <= ACTIVE;
                            link_up <= 1'b1;
                            com_cnt <= '0;
                        end else begin
                            com_cnt <= com_cnt + NW'(1);
                        end
                    end
                end
                ACTIVE: begin
                    link_up <= 1'b1;
                    if (lane_ready) begin
                        if (|ne) begin
                            data_out   <= head[grant];
                            valid_out  <= 1'b1;
                            sel_out    <= grant;
                            last_grant <= grant;
                        end else begin
                            data_out  <= COM_SYMBOL;
                            valid_out <= 1'b0;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_lane_arb.sv
// tb_phy_lane_arb: directed vectors with a scoreboard queue and output monitor.
// Expected lane bytes are queued as {sel, data} in hand-computed order.
module tb_phy_lane_arb;

    logic       clk_f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in_0 = '0;
    logic       valid_in_0 = 1'b0;
    logic       ready_out_0;
    logic [7:0] data_in_1 = '0;
    logic       valid_in_1 = 1'b0;
    logic       ready_out_1;
    logic       lane_ready = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       sel_out;
    logic       link_up;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;
    logic       mon_lr;

    phy_lane_arb dut (
        .clk_f       (clk_f),
        .reset       (reset),
        .data_in_0   (data_in_0),
        .valid_in_0  (valid_in_0),
        .ready_out_0 (ready_out_0),
        .data_in_1   (data_in_1),
        .valid_in_1  (valid_in_1),
        .ready_out_1 (ready_out_1),
        .lane_ready  (lane_ready),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .sel_out     (sel_out),
        .link_up     (link_up)
    );

    always #5 clk_f = ~clk_f;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_f);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name, input logic lu);
        check({name, "_data"}, 32'(data_out), 32'hBC);
        check({name, "_valid"}, 32'(valid_out), 32'h0);
        check({name, "_link"}, 32'(link_up), 32'(lu));
    endtask

    task automatic reset_seq();
        reset      = 1'b1;
        lane_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Monitor: every byte the lane accepts with valid_out=1 is scored
    always @(posedge clk_f) begin
        mon_lr = lane_ready & ~reset;
        #1;
        if (mon_lr && !reset && valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL mon_unexpected got sel=%0d data=%h want none",
                         sel_out, data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({sel_out, data_out} !== mon_exp) begin
                    failures++;
                    $display("FAIL mon_byte got sel=%0d data=%h want sel=%0d data=%h",
                             sel_out, data_out, mon_exp[8], mon_exp[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(2);
        check_idle("rst", 1'b0);
        check("rst_sel", 32'(sel_out), 32'h0);
        check("rst_rdy0", 32'(ready_out_0), 32'h1);
        check("rst_rdy1", 32'(ready_out_1), 32'h1);

        // Training: four COM cycles then link up, filler continues
        reset      = 1'b0;
        lane_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_idle($sformatf("train%0d", k), (k == 4));
        end
        tick();
        check_idle("fill_after_train", 1'b1);

        // Byte pushed during training is the first active output
        reset_seq();
        data_in_0  = 8'h11;
        valid_in_0 = 1'b1;
        exp_q.push_back({1'b0, 8'h11});
        tick();
        valid_in_0 = 1'b0;
        lane_ready = 1'b1;
        tick(4);
        check("t2_link", 32'(link_up), 32'h1);
        tick();
        tick();
        check_idle("t2_fill", 1'b1);
        check("t2_sel_hold", 32'(sel_out), 32'h0);

        // Two requesters contend from the start of ACTIVE
        reset_seq();
        data_in_0  = 8'hA0;
        valid_in_0 = 1'b1;
        data_in_1  = 8'hB0;
        valid_in_1 = 1'b1;
        tick();
        data_in_0 = 8'hA1;
        data_in_1 = 8'hB1;
        tick();
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
`ifdef PHY_LANE_ARB_STRICT_PRIO_EN
        exp_q.push_back({1'b0, 8'hA0});
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b1, 8'hB0});
        exp_q.push_back({1'b1, 8'hB1});
`else
        exp_q.push_back({1'b0, 8'hA0});
        exp_q.push_back({1'b1, 8'hB0});
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b1, 8'hB1});
`endif
        lane_ready = 1'b1;
        tick(4);
        tick(4);
        tick();
        check_idle("t3_fill", 1'b1);
        check("t3_sel_hold", 32'(sel_out), 32'h1);

        // Fill ch1 past capacity while the lane stalls
        lane_ready = 1'b0;
        valid_in_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in_1 = 8'hC0 + 8'(i);
            check($sformatf("t4_rdy_%0d", i), 32'(ready_out_1), 32'h1);
            exp_q.push_back({1'b1, data_in_1});
            tick();
        end
        data_in_1 = 8'hC4;
        check("t4_full", 32'(ready_out_1), 32'h0);
        exp_q.push_back({1'b1, 8'hC4});
        tick(2);
        check("t4_full_hold", 32'(ready_out_1), 32'h0);
        check("t4_rdy0", 32'(ready_out_0), 32'h1);
        lane_ready = 1'b1;
        tick();
        check("t4_rdy_after_pop", 32'(ready_out_1), 32'h1);
        tick();
        valid_in_1 = 1'b0;
        tick(4);
        check_idle("t4_fill", 1'b1);

        // Output holds across lane stalls
        lane_ready = 1'b0;
        data_in_0  = 8'h01;
        valid_in_0 = 1'b1;
        exp_q.push_back({1'b0, 8'h01});
        tick();
        data_in_0 = 8'h02;
        exp_q.push_back({1'b0, 8'h02});
        tick();
        valid_in_0 = 1'b0;
        lane_ready = 1'b1;
        tick();
        lane_ready = 1'b0;
        tick();
        check("t5_hold1", 32'({valid_out, data_out}), 32'h101);
        tick();
        check("t5_hold2", 32'({valid_out, data_out}), 32'h101);
        lane_ready = 1'b1;
        tick();
        tick();
        check_idle("t5_fill", 1'b1);

        // Reset with bytes queued discards them and retrains
        lane_ready = 1'b0;
        valid_in_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in_1 = 8'hD0 + 8'(i);
            tick();
        end
        valid_in_1 = 1'b0;
        exp_q.push_back({1'b1, 8'hD0});
        lane_ready = 1'b1;
        tick();
        lane_ready = 1'b0;
        tick();
        check("t6_pre_sel", 32'(sel_out), 32'h1);
        check("t6_pre_valid", 32'(valid_out), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_idle("t6_async", 1'b0);
        check("t6_async_sel", 32'(sel_out), 32'h0);
        check("t6_async_rdy0", 32'(ready_out_0), 32'h1);
        check("t6_async_rdy1", 32'(ready_out_1), 32'h1);
        tick();
        reset      = 1'b0;
        lane_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_idle($sformatf("t6_train%0d", k), (k == 4));
        end
        tick(3);
        check_idle("t6_no_stale", 1'b1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
